// File: rtl/phase_sequencer.sv
// Phase sequencer: steps the 3-bit instruction phase for the multi-cycle core, handles start/stop, single-step, memory stalls and HLT.
// All outputs registered (one edge per phase step); mem_wait holds the phase in masked phases and never cuts an instruction short.
module phase_sequencer #(
  parameter int unsigned       NPHASE    = 6,
  parameter logic [NPHASE-1:0] WAIT_MASK = 6'b010001,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exec,
  input  logic             step_mode,
  input  logic             hlt,
  input  logic             mem_wait,
  output logic [2:0]       phase,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] inst_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [2:0]       LAST_PHASE = 3'(NPHASE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state, state_n;
  logic [2:0]       phase_n;
  logic             stop_pend, stop_pend_n;
  logic [CNT_W-1:0] inst_count_n;
  logic [7:0]       wait_mask_ext;
  logic             stall;

  // Widen the mask so any 3-bit phase indexes it safely.
  assign wait_mask_ext = 8'(WAIT_MASK);
  assign stall         = mem_wait && wait_mask_ext[phase];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      phase      <= 3'd0;
      stop_pend  <= 1'b0;
      inst_count <= '0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      stop_pend  <= stop_pend_n;
      inst_count <= inst_count_n;
    end
  end

  always_comb begin
    state_n      = state;
    phase_n      = phase;
    stop_pend_n  = stop_pend;
    inst_count_n = inst_count;
    case (state)
      IDLE: begin
        phase_n     = 3'd0;
        stop_pend_n = 1'b0;
        if (exec) state_n = RUN;
      end
      RUN: begin
        if (hlt && (phase != 3'd0)) begin
          state_n      = HALT;
          phase_n      = 3'd0;
          stop_pend_n  = 1'b0;
          inst_count_n = inst_count + CNT_ONE;
        end else begin
          if (exec) stop_pend_n = 1'b1;
          if (stall) begin
            phase_n = phase;
          end else if (phase < LAST_PHASE) begin
            phase_n = phase + 3'd1;
          end else begin
            // Boundary: an exec arriving this very cycle stops here too.
            phase_n      = 3'd0;
            inst_count_n = inst_count + CNT_ONE;
            stop_pend_n  = 1'b0;
            if (step_mode || stop_pend || exec) state_n = IDLE;
          end
        end
      end
      HALT: begin
        phase_n     = 3'd0;
        stop_pend_n = 1'b0;
      end
      default: begin
        state_n     = IDLE;
        phase_n     = 3'd0;
        stop_pend_n = 1'b0;
      end
    endcase
  end

  assign running = (state == RUN);
  assign halted  = (state == HALT);

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Generates the 3-bit `phase` that drives the control decoder of the 16-bit multi-cycle processor.
- Sequences execution: start/stop, single-step, memory-wait stalls and HLT.
- Keeps a retired-instruction counter for debug display.
- Sits between the front-panel inputs / memory interface and the control decoder. It consumes the decoder's `hlt` and feeds it `phase`.

Parameters:
- NPHASE, 6: number of phases per instruction; phase counts 0..NPHASE-1.
- WAIT_MASK, 6'b010001: bit i set means `mem_wait` may stall phase i. Default stalls phase 0 (fetch) and phase 4 (memory access).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- exec  input  1  start/stop request; a single-cycle pulse, debounced and synchronised upstream.
- step_mode  input  1  1 = stop after each instruction; sampled at the instruction boundary.
- hlt  input  1  HLT decoded by the control decoder; combinational from the current instruction and phase.
- mem_wait  input  1  memory not ready; holds the current phase if masked in WAIT_MASK.
- phase  output  3  current phase, registered.
- running  output  1  1 while in state RUN.
- halted  output  1  1 while in state HALT.
- inst_count  output  CNT_W  instructions retired since reset.

Behaviour:
- State machine: IDLE, RUN, HALT. An internal flag `stop_pend` is also held.
- Reset (rst=0, asynchronous): state=IDLE, phase=0, stop_pend=0, running=0, halted=0, inst_count=0. Reset mid-instruction abandons the instruction immediately; inst_count is not incremented.
- running and halted are decoded from registered state. They are never both 1.
- IDLE:
  - phase held at 0; mem_wait and hlt ignored.
  - exec=1 → RUN on the next edge, phase stays 0. The first RUN cycle is phase 0.
- RUN, per edge, first matching rule applies:
  1. hlt=1 and phase!=0 → state=HALT, phase=0, inst_count+1. Wins over mem_wait, exec and step_mode.
  2. mem_wait=1 and WAIT_MASK[phase]=1 → phase held. A stall may last any number of cycles.
  3. phase<NPHASE-1 → phase+1.
  4. phase==NPHASE-1 (instruction boundary) → phase=0 and inst_count+1. Then state=IDLE if step_mode=1 or stop_pend=1, else state stays RUN. stop_pend is cleared at the boundary.
- exec=1 in RUN sets stop_pend, including during a stall cycle. The stop takes effect only at the next boundary; an instruction is never cut short. A second exec while stop_pend=1 has no further effect.
- If exec=1 and the boundary fall in the same cycle, the current boundary stops execution. stop_pend is not left set.
- hlt=1 while phase==0 is ignored, since the decoder never legitimately asserts it there.
- HALT: phase=0, halted=1. exec, step_mode, mem_wait and hlt are ignored; only reset exits.
- inst_count wraps from 2^CNT_W-1 to 0 with no flag.
- phase never takes values ≥ NPHASE.

Test Plan:
- Reset, then 3 idle cycles → phase=0, running=0, halted=0, inst_count=0. exec pulse → phase sequence 0,1,2,3,4,5,0,1… from the next cycle. inst_count=1 on the edge where 5→0.
- step_mode=1, exec pulse → exactly one pass 0..5, then IDLE with phase=0, running=0, inst_count=1. A second exec pulse → another single pass, inst_count=2.
- RUN with mem_wait=1 for 4 cycles starting at phase 4 → phase stays 4 for 4 cycles, then goes 5,0. mem_wait=1 in phase 2 → no stall, phase goes 2→3.
- hlt=1 at phase 3 → next cycle halted=1, phase=0, inst_count+1. Further exec pulses and hlt toggles change nothing. rst low → IDLE with all outputs 0.
- exec pulse at phase 1 in RUN → instruction completes through phase 5, then IDLE at phase 0. exec coincident with the phase-5 edge → stops at that boundary; a new exec restarts normally.
- Preload inst_count near wrap (CNT_W=4, 15 instructions, then one more) → count reads 0. rst asserted mid-phase 3 → outputs at reset values immediately, asynchronous to clk.
